// File: rtl/gamma_stream_pkg.sv
// Shared definitions for the gamma pipeline read-side stream logic:
// drain FSM encoding, default frame geometry and a counter width helper.
package gamma_stream_pkg;

  typedef enum logic {
    WAIT_RST = 1'b0,
    RUN      = 1'b1
  } rd_state_e;

  localparam int DEF_LINEWIDTH   = 640;
  localparam int DEF_FRAMEHEIGHT = 480;

  // Bits needed to index n items; never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready pixel stream with line and frame framing flags.
interface fifo_stream_reader_if #(
  parameter int DATAWIDTH = 8
) ();

  logic [DATAWIDTH-1:0] streamData;
  logic                 streamValid;
  logic                 streamReady;
  logic                 streamLast;
  logic                 streamFirst;

  modport master (
    output streamData, streamValid, streamLast, streamFirst,
    input  streamReady
  );

  modport slave (
    input  streamData, streamValid, streamLast, streamFirst,
    output streamReady
  );

endinterface

// File: rtl/fifo_skid_buffer.sv
// Circular buffer catching FIFO read returns; the head word is always
// visible on pop_data so the stream side needs no extra register stage.
module fifo_skid_buffer
  import gamma_stream_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int BUFDEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DATAWIDTH-1:0]           push_data,
  input  logic                           pop,
  output logic [DATAWIDTH-1:0]           pop_data,
  output logic [cnt_width(BUFDEPTH):0]   count
);

  localparam int PW = cnt_width(BUFDEPTH);

  logic [DATAWIDTH-1:0] mem_q [BUFDEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW:0]          count_q, count_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the clock-crossing FIFO with credit-limited reads and presents the
// words as a framed pixel stream to the gamma LUT stage.
module fifo_stream_reader
  import gamma_stream_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int READLATENCY = 2,
  parameter int BUFDEPTH    = 4,
  parameter int LINEWIDTH   = DEF_LINEWIDTH,
  parameter int FRAMEHEIGHT = DEF_FRAMEHEIGHT
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic                      fifoRstDone,
  input  logic                      fifoEmpty,
  input  logic                      fifoDataOutValid,
  input  logic [DATAWIDTH-1:0]      fifoDataOut,
  output logic                      fifoReadEn,
  fifo_stream_reader_if.master      stream,
  output logic                      frameDone,
  output logic                      protocolErr
);

  localparam int PW   = cnt_width(BUFDEPTH);
  // Inflight stays wide enough even for a latency beyond the buffer depth.
  localparam int IW   = cnt_width((BUFDEPTH > READLATENCY) ? BUFDEPTH : READLATENCY) + 1;
  localparam int COLW = cnt_width(LINEWIDTH);
  localparam int ROWW = cnt_width(FRAMEHEIGHT);

  localparam logic [IW:0]      CREDIT_LIMIT = (IW+1)'(BUFDEPTH);
  localparam logic [PW:0]      OCC_FULL     = (PW+1)'(BUFDEPTH);
  localparam logic [COLW-1:0]  COL_LAST     = COLW'(LINEWIDTH - 1);
  localparam logic [ROWW-1:0]  ROW_LAST     = ROWW'(FRAMEHEIGHT - 1);

  rd_state_e       state_q, state_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  logic            frame_done_q, frame_done_d;
  logic            protocol_err_q, protocol_err_d;

  logic [PW:0]          occupancy;
  logic [DATAWIDTH-1:0] head_data;
  logic [IW:0]          credit_sum;
  logic                 in_run, flush, word_bad, push, rsp, handshake;

  assign in_run     = (state_q == RUN);
  assign flush      = in_run && !fifoRstDone;
  assign credit_sum = {{(IW-PW){1'b0}}, occupancy} + {1'b0, inflight_q};
  assign fifoReadEn = in_run && !fifoEmpty && (credit_sum < CREDIT_LIMIT);

  // A return with no read outstanding, or with no room, is dropped and flagged.
  assign word_bad  = in_run && fifoDataOutValid && (inflight_q == '0 || occupancy == OCC_FULL);
  assign push      = in_run && fifoDataOutValid && !word_bad;
  assign rsp       = fifoDataOutValid && (inflight_q != '0);
  assign handshake = stream.streamValid && stream.streamReady;

  assign stream.streamValid = (occupancy != '0);
  assign stream.streamData  = head_data;
  assign stream.streamLast  = stream.streamValid && (col_q == COL_LAST);
  assign stream.streamFirst = stream.streamValid && (col_q == '0) && (row_q == '0);
  assign frameDone          = frame_done_q;
  assign protocolErr        = protocol_err_q;

  fifo_skid_buffer #(
    .DATAWIDTH (DATAWIDTH),
    .BUFDEPTH  (BUFDEPTH)
  ) u_skid (
    .clk       (clkIn),
    .srst      (rstIn),
    .flush     (flush),
    .push      (push),
    .push_data (fifoDataOut),
    .pop       (handshake),
    .pop_data  (head_data),
    .count     (occupancy)
  );

  always_comb begin
    state_d        = state_q;
    inflight_d     = inflight_q;
    col_d          = col_q;
    row_d          = row_q;
    frame_done_d   = 1'b0;
    protocol_err_d = protocol_err_q | word_bad;

    case (state_q)
      WAIT_RST: if (fifoRstDone)  state_d = RUN;
      RUN:      if (!fifoRstDone) state_d = WAIT_RST;
      default:                    state_d = WAIT_RST;
    endcase

    // Losing the FIFO resets everything downstream of it, like rstIn does.
    if (flush) begin
      inflight_d = '0;
      col_d      = '0;
      row_d      = '0;
    end else begin
      if (fifoReadEn && !rsp)      inflight_d = inflight_q + 1'b1;
      else if (!fifoReadEn && rsp) inflight_d = inflight_q - 1'b1;

      if (handshake) begin
        frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q        <= WAIT_RST;
      inflight_q     <= '0;
      col_q          <= '0;
      row_q          <= '0;
      frame_done_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= inflight_d;
      col_q          <= col_d;
      row_q          <= row_d;
      frame_done_q   <= frame_done_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a latency-2 FIFO model feeding the
// reader, and a pixel scoreboard checking data order and framing flags.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int RL = 2;
  localparam int BD = 4;
  localparam int LW = 4;
  localparam int FH = 2;
  localparam int FRAME_PIX = LW * FH;

  logic          clkIn = 1'b0;
  logic          rstIn = 1'b1;
  logic          fifoRstDone = 1'b0;
  logic          fifoEmpty = 1'b1;
  logic          fifoDataOutValid = 1'b0;
  logic [DW-1:0] fifoDataOut = '0;
  logic          fifoReadEn;
  logic          frameDone;
  logic          protocolErr;

  fifo_stream_reader_if #(.DATAWIDTH(DW)) stream_if ();

  fifo_stream_reader #(
    .DATAWIDTH   (DW),
    .READLATENCY (RL),
    .BUFDEPTH    (BD),
    .LINEWIDTH   (LW),
    .FRAMEHEIGHT (FH)
  ) dut (
    .clkIn            (clkIn),
    .rstIn            (rstIn),
    .fifoRstDone      (fifoRstDone),
    .fifoEmpty        (fifoEmpty),
    .fifoDataOutValid (fifoDataOutValid),
    .fifoDataOut      (fifoDataOut),
    .fifoReadEn       (fifoReadEn),
    .stream           (stream_if),
    .frameDone        (frameDone),
    .protocolErr      (protocolErr)
  );

  always #5 clkIn = ~clkIn;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model and scoreboard state
  int       fifo_avail = 0;
  int       next_word  = 0;
  int       exp_data   = 0;
  int       pix_idx    = 0;
  int       rd_count   = 0;
  int       hs_count   = 0;
  int       fd_count   = 0;
  bit       fd_exp     = 1'b0;
  bit       exp_err    = 1'b0;
  bit       rd_en_obs  = 1'b0;
  bit       pv [RL];
  logic [DW-1:0] pd [RL];

  // Staged controls, applied just after the next rising edge
  bit rst_s   = 1'b1;
  bit done_s  = 1'b0;
  bit ready_s = 1'b0;
  bit inj_s   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
    pv[1] = pv[0];
    pd[1] = pd[0];
    pv[0] = rd_en_obs;
    pd[0] = '0;
    if (rd_en_obs) begin
      if (fifo_avail == 0) chk("read_while_empty", 1, 0);
      pd[0] = next_word[DW-1:0];
      next_word++;
      fifo_avail--;
    end
    rstIn                 = rst_s;
    fifoRstDone           = done_s;
    stream_if.streamReady = ready_s;
    fifoEmpty             = (fifo_avail <= 0);
    fifoDataOutValid      = pv[1] || inj_s;
    fifoDataOut           = inj_s ? 8'hEE : pd[1];
    @(negedge clkIn);
    chk("frameDone", frameDone, fd_exp);
    chk("protocolErr", protocolErr, exp_err);
    rd_en_obs = fifoReadEn;
    if (rd_en_obs) rd_count++;
    if (frameDone) fd_count++;
    fd_exp = 1'b0;
    if (stream_if.streamValid && stream_if.streamReady && !rstIn) begin
      $display("pix %0d data %02h first %0b last %0b", pix_idx, stream_if.streamData,
               stream_if.streamFirst, stream_if.streamLast);
      chk("data", stream_if.streamData, exp_data & 255);
      chk("first", stream_if.streamFirst, (pix_idx % FRAME_PIX) == 0);
      chk("last", stream_if.streamLast, (pix_idx % LW) == LW - 1);
      fd_exp = ((pix_idx % FRAME_PIX) == FRAME_PIX - 1);
      exp_data++;
      pix_idx++;
      hs_count++;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rd_en"}, fifoReadEn, 0);
    chk({tag, "_valid"}, stream_if.streamValid, 0);
    chk({tag, "_last"}, stream_if.streamLast, 0);
    chk({tag, "_first"}, stream_if.streamFirst, 0);
    chk({tag, "_frameDone"}, frameDone, 0);
    chk({tag, "_protocolErr"}, protocolErr, 0);
  endtask

  int base;

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    pd[0] = '0;   pd[1] = '0;
    stream_if.streamReady = 1'b0;
    fifo_avail = 256;

    // Reset with a non-empty FIFO that is not yet out of reset
    tick();
    tick();
    rst_s = 1'b0;
    tick();
    chk_reset_values("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait_rst_rd_en", fifoReadEn, 0);
    end

    // FIFO comes up: first read next cycle, first pixel three cycles later
    done_s  = 1'b1;
    ready_s = 1'b1;
    tick();
    chk("rd_en_before_run", fifoReadEn, 0);
    tick();
    chk("rd_en_first", fifoReadEn, 1);
    tick();
    chk("valid_t1", stream_if.streamValid, 0);
    tick();
    chk("valid_t2", stream_if.streamValid, 0);
    tick();
    chk("valid_t3", stream_if.streamValid, 1);
    for (int i = 0; i < 255; i++) begin
      tick();
      chk("throughput_valid", stream_if.streamValid, 1);
    end
    for (int i = 0; i < 4; i++) tick();
    chk("drained_valid", stream_if.streamValid, 0);
    chk("pixels_after_seq", hs_count, 256);

    // Backpressure: credits cap reads at the buffer depth
    ready_s    = 1'b0;
    fifo_avail = 24;
    rd_count   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 4) begin
        chk("hold_valid", stream_if.streamValid, 1);
        chk("hold_data", stream_if.streamData, exp_data & 255);
      end
    end
    chk("bp_read_count", rd_count, BD);
    ready_s = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("pixels_after_bp", hs_count, 280);

    // Framing with alternating ready: one full frame plus the next first pixel
    fifo_avail = 9;
    fd_count   = 0;
    base       = hs_count;
    for (int i = 0; i < 40; i++) begin
      ready_s = i[0];
      tick();
    end
    ready_s = 1'b1;
    tick();
    chk("frame_pixels", hs_count - base, 9);
    chk("frame_done_pulses", fd_count, 1);

    // Unsolicited return word: flagged, dropped, sticky
    inj_s = 1'b1;
    tick();
    inj_s   = 1'b0;
    exp_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("inject_dropped_valid", stream_if.streamValid, 0);
    end
    fifo_avail = 7;
    base       = hs_count;
    for (int i = 0; i < 15; i++) tick();
    chk("post_err_pixels", hs_count - base, 7);
    chk("err_sticky", protocolErr, 1);

    // Reset mid-frame with reads in flight
    fifo_avail = 13;
    base       = hs_count;
    for (int i = 0; i < 6; i++) tick();
    chk("midframe_pixels", hs_count - base, 3);
    rst_s  = 1'b1;
    done_s = 1'b0;
    tick();
    rst_s   = 1'b0;
    exp_err = 1'b0;
    tick();
    chk_reset_values("midreset");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("late_return_ignored", stream_if.streamValid, 0);
    end
    pix_idx  = 0;
    exp_data = next_word;
    done_s   = 1'b1;
    base     = hs_count;
    for (int i = 0; i < 20; i++) tick();
    chk("restart_pixels", hs_count - base, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
